// File: rtl/alu_pkg.sv
// Shared types for the ALU result stage: opcode enumeration and the
// active-low {g,f,e,d,c,b,a} hexadecimal 7-segment decoder.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_SUM  = 4'd0,
        OP_REST = 4'd1,
        OP_MULT = 4'd2,
        OP_DIV  = 4'd3,
        OP_MOD  = 4'd4,
        OP_AND  = 4'd5,
        OP_OR   = 4'd6,
        OP_XOR  = 4'd7,
        OP_SHR  = 4'd8,
        OP_SHL  = 4'd9
    } alu_op_t;

    localparam alu_op_t OP_LAST = OP_SHL;

    // Segment order {g,f,e,d,c,b,a}; a segment is lit when its bit is 0.
    function automatic logic [6:0] hex7seg(input logic [3:0] nib);
        logic [6:0] seg;
        seg = 7'b1111111;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/alu_result_stage_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, consecutive-cycle debouncer
// and a one-cycle pulse on the debounced rising edge.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_meta;
    logic          sync_q;
    logic          deb_q;
    logic [CW-1:0] cnt_q;
    logic          differ;
    logic          expire;

    assign differ = sync_q ^ deb_q;
    assign expire = differ && (cnt_q == CNT_LAST);

    // NOTE: every flop here is updated with <= so all of them sample the
    // pre-edge values; a blocking = would let sync_q see this edge's sync_meta.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
            deb_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync_meta <= btn_raw;
            sync_q    <= sync_meta;
            if (!differ) begin
                cnt_q <= '0;
            end else if (expire) begin
                cnt_q <= '0;
                deb_q <= sync_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level = deb_q;
    // Combinational so the consumer acts on the same edge that sets level.
    assign rise  = expire && sync_q;

endmodule

// File: rtl/alu_result_stage.sv
// Registered output stage behind the ALU: button-stepped opcode, result mux
// and a one-deep valid/ready sample register. Optional 7-segment outputs are
// enabled by defining ALU_SEG7_EN.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         btn_next,
    input  logic [N:0]   sum_i,
    input  logic [N:0]   rest_i,
    input  logic [N:0]   mult_i,
    input  logic [N:0]   div_i,
    input  logic [N:0]   mod_i,
    input  logic [N:0]   and_i,
    input  logic [N:0]   or_i,
    input  logic [N:0]   xor_i,
    input  logic [N:0]   shr_i,
    input  logic [N:0]   shl_i,
    output logic [3:0]   op,
    output logic [N:0]   result,
    output logic         flag_z,
    output logic         flag_c,
    output logic         res_valid,
    input  logic         res_ready
`ifdef ALU_SEG7_EN
    ,
    output logic [6:0]   seg_lo,
    output logic [6:0]   seg_hi
`endif
);

    alu_op_t    op_q;
    alu_op_t    op_next;
    logic       step;
    logic       deb_level_unused;
    logic [N:0] sel;
    logic       load;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_raw(btn_next),
        .level  (deb_level_unused),
        .rise   (step)
    );

    always_comb begin
        if (op_q == OP_LAST) op_next = OP_SUM;
        else                 op_next = alu_op_t'(op_q + 4'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    op_q <= OP_SUM;
        else if (step) op_q <= op_next;
    end

    // NOTE: sel gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        sel = '0;
        case (op_q)
            OP_SUM:  sel = sum_i;
            OP_REST: sel = rest_i;
            OP_MULT: sel = mult_i;
            OP_DIV:  sel = div_i;
            OP_MOD:  sel = mod_i;
            OP_AND:  sel = and_i;
            OP_OR:   sel = or_i;
            OP_XOR:  sel = xor_i;
            OP_SHR:  sel = shr_i;
            OP_SHL:  sel = shl_i;
            default: sel = '0;
        endcase
    end

    // Capture uses the current op; a simultaneous step shows at the next load.
    assign load = !res_valid || res_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            res_valid <= 1'b0;
        end else if (load) begin
            result    <= sel;
            flag_z    <= (sel == '0);
            flag_c    <= sel[N];
            res_valid <= 1'b1;
        end
    end

    assign op = op_q;

`ifdef ALU_SEG7_EN
    logic [15:0] sel_ext;
    assign sel_ext = 16'(sel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_lo <= 7'b1000000;
            seg_hi <= 7'b1000000;
        end else if (load) begin
            seg_lo <= hex7seg(sel_ext[3:0]);
            seg_hi <= hex7seg(sel_ext[7:4]);
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage (N=4, DEBOUNCE_CYCLES=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_alu_result_stage;

    localparam int N = 4;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_next;
    logic [N:0] sum_i, rest_i, mult_i, div_i, mod_i;
    logic [N:0] and_i, or_i, xor_i, shr_i, shl_i;
    logic [3:0] op;
    logic [N:0] result;
    logic       flag_z, flag_c, res_valid, res_ready;
`ifdef ALU_SEG7_EN
    logic [6:0] seg_lo, seg_hi;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_result_stage #(.N(N), .DEBOUNCE_CYCLES(D)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_next (btn_next),
        .sum_i    (sum_i),
        .rest_i   (rest_i),
        .mult_i   (mult_i),
        .div_i    (div_i),
        .mod_i    (mod_i),
        .and_i    (and_i),
        .or_i     (or_i),
        .xor_i    (xor_i),
        .shr_i    (shr_i),
        .shl_i    (shl_i),
        .op       (op),
        .result   (result),
        .flag_z   (flag_z),
        .flag_c   (flag_c),
        .res_valid(res_valid),
        .res_ready(res_ready)
`ifdef ALU_SEG7_EN
        ,
        .seg_lo   (seg_lo),
        .seg_hi   (seg_hi)
`endif
    );

    // Hand-chosen ALU result values (with sum_i at its initial 0x0C).
    function automatic logic [N:0] exp_res(input int k);
        case (k)
            0: return 5'h0C;
            1: return 5'h00;
            2: return 5'h03;
            3: return 5'h04;
            4: return 5'h05;
            5: return 5'h06;
            6: return 5'h07;
            7: return 5'h08;
            8: return 5'h09;
            default: return 5'h1A;
        endcase
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press();
        btn_next = 1'b1;
        cyc(10);
        btn_next = 1'b0;
        cyc(10);
    endtask

    // Observed bundle {op, result, flag_z, flag_c, res_valid}.
    function automatic logic [11:0] obs();
        return {op, result, flag_z, flag_c, res_valid};
    endfunction

    task automatic test_reset();
        logic [11:0] e;
        rst_n = 1'b0;
        cyc(2);
        e = {4'd0, 5'h00, 1'b0, 1'b0, 1'b0};
        vectors++;
        if (obs() !== e) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected %h", obs(), e);
        end
`ifdef ALU_SEG7_EN
        vectors++;
        if ({seg_hi, seg_lo} !== {7'b1000000, 7'b1000000}) begin
            miscompares++;
            $display("FAIL reset_seg: got %b_%b expected 1000000_1000000", seg_hi, seg_lo);
        end
`endif
        rst_n = 1'b1;
        cyc(1);
        e = {4'd0, 5'h0C, 1'b0, 1'b0, 1'b1};
        vectors++;
        if (obs() !== e) begin
            miscompares++;
            $display("FAIL first_capture: got %h expected %h", obs(), e);
        end
    endtask

    task automatic test_clean_presses();
        logic [11:0] e;
        logic [N:0]  r;
        for (int i = 1; i <= 10; i++) begin
            press();
            r = exp_res(i % 10);
            e = {4'(i % 10), r, (r == 5'h00), r[N], 1'b1};
            vectors++;
            if (obs() !== e) begin
                miscompares++;
                $display("FAIL press_%0d: got %h expected %h", i, obs(), e);
            end
`ifdef ALU_SEG7_EN
            if (i == 9) begin
                vectors++;
                if ({seg_hi, seg_lo} !== {7'b1111001, 7'b0001000}) begin
                    miscompares++;
                    $display("FAIL seg_1A: got %b_%b expected 1111001_0001000", seg_hi, seg_lo);
                end
            end
`endif
        end
    endtask

    task automatic test_glitch();
        btn_next = 1'b1;
        cyc(3);
        btn_next = 1'b0;
        cyc(10);
        vectors++;
        if (op !== 4'd0) begin
            miscompares++;
            $display("FAIL glitch_op: got %0d expected 0", op);
        end
    endtask

    task automatic test_hold();
        logic [11:0] e;
        res_ready = 1'b0;
        cyc(1);
        sum_i = 5'h13;
        cyc(3);
        e = {4'd0, 5'h0C, 1'b0, 1'b0, 1'b1};
        vectors++;
        if (obs() !== e) begin
            miscompares++;
            $display("FAIL hold: got %h expected %h", obs(), e);
        end
        res_ready = 1'b1;
        cyc(1);
        e = {4'd0, 5'h13, 1'b0, 1'b1, 1'b1};
        vectors++;
        if (obs() !== e) begin
            miscompares++;
            $display("FAIL release_hold: got %h expected %h", obs(), e);
        end
    endtask

    task automatic test_step_timing();
        // Edges 1-2 synchronize, edges 3-6 count; op moves on edge 6.
        btn_next = 1'b1;
        cyc(5);
        vectors++;
        if (op !== 4'd0) begin
            miscompares++;
            $display("FAIL step_early: got op %0d expected 0", op);
        end
        cyc(1);
        vectors++;
        if ({op, result} !== {4'd1, 5'h13}) begin
            miscompares++;
            $display("FAIL step_edge: got op %0d result %h expected op 1 result 13", op, result);
        end
        cyc(1);
        vectors++;
        if ({result, flag_z} !== {5'h00, 1'b1}) begin
            miscompares++;
            $display("FAIL step_capture: got result %h z %b expected 00 z 1", result, flag_z);
        end
        btn_next = 1'b0;
        cyc(10);
    endtask

    task automatic test_bounce();
        btn_next = 1'b1; cyc(1);
        btn_next = 1'b0; cyc(1);
        btn_next = 1'b1; cyc(6);
        btn_next = 1'b0; cyc(10);
        vectors++;
        if ({op, result} !== {4'd2, 5'h03}) begin
            miscompares++;
            $display("FAIL bounce: got op %0d result %h expected op 2 result 03", op, result);
        end
    endtask

    task automatic test_async_reset();
        logic [11:0] e;
        for (int i = 0; i < 5; i++) press();
        vectors++;
        if ({op, result} !== {4'd7, 5'h08}) begin
            miscompares++;
            $display("FAIL reach_op7: got op %0d result %h expected op 7 result 08", op, result);
        end
        // Two sync edges plus two count edges leave the counter at 2.
        btn_next = 1'b1;
        cyc(4);
        #2;
        rst_n = 1'b0;
        #1;
        e = {4'd0, 5'h00, 1'b0, 1'b0, 1'b0};
        vectors++;
        if (obs() !== e) begin
            miscompares++;
            $display("FAIL async_reset: got %h expected %h", obs(), e);
        end
`ifdef ALU_SEG7_EN
        vectors++;
        if ({seg_hi, seg_lo} !== {7'b1000000, 7'b1000000}) begin
            miscompares++;
            $display("FAIL async_reset_seg: got %b_%b expected 1000000_1000000", seg_hi, seg_lo);
        end
`endif
        cyc(1);
        rst_n = 1'b1;
        cyc(2);
        btn_next = 1'b0;
        cyc(12);
        e = {4'd0, 5'h13, 1'b0, 1'b1, 1'b1};
        vectors++;
        if (obs() !== e) begin
            miscompares++;
            $display("FAIL partial_press_discarded: got %h expected %h", obs(), e);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        btn_next  = 1'b0;
        res_ready = 1'b1;
        sum_i  = 5'h0C; rest_i = 5'h00; mult_i = 5'h03; div_i = 5'h04; mod_i = 5'h05;
        and_i  = 5'h06; or_i   = 5'h07; xor_i  = 5'h08; shr_i = 5'h09; shl_i = 5'h1A;

        test_reset();
        test_clean_presses();
        test_glitch();
        test_hold();
        test_step_timing();
        test_bounce();
        test_async_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
